ghost_ai_multi: RTL and testbench

//  Next-generation ghost steering engine: one shared decision datapath serves NUM_GHOSTS ghosts, time-multiplexed.

---
 rtl/ghost_ai_multi.sv | 229 ++++++++++++++++++++++
 tb/tb_ghost_ai_multi.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ghost_ai_multi.sv
// Ghost steering engine: one shared decision datapath serves NUM_GHOSTS ghosts,
// one ghost per clock after each accepted tick. It also runs the global
// SCATTER/CHASE/FRIGHT mode sequencer and keeps per-ghost previous directions.
module ghost_ai_multi #(
  parameter int unsigned               NUM_GHOSTS    = 4,
  parameter int unsigned               X_W           = 11,
  parameter int unsigned               Y_W           = 10,
  parameter logic [15:0]               SCATTER_TICKS = 16'd420,
  parameter logic [15:0]               CHASE_TICKS   = 16'd1200,
  parameter logic [15:0]               FRIGHT_TICKS  = 16'd360,
  parameter logic [NUM_GHOSTS*X_W-1:0] CORNER_X      = '0,
  parameter logic [NUM_GHOSTS*Y_W-1:0] CORNER_Y      = '0,
  parameter logic [15:0]               LFSR_SEED     = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    power_pellet,
  input  logic [X_W-1:0]          pacman_x,
  input  logic [Y_W-1:0]          pacman_y,
  input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
  input  logic [NUM_GHOSTS*4-1:0] valid_moves,
  output logic [NUM_GHOSTS*4-1:0] move_dir,
  output logic                    round_done,
  output logic [1:0]              mode,
  output logic                    overrun
);

  typedef enum logic [1:0] {M_SCATTER = 2'b00, M_CHASE = 2'b01, M_FRIGHT = 2'b10} mode_e;

  localparam logic [3:0] D_RIGHT = 4'b0001;
  localparam logic [3:0] D_UP    = 4'b0010;
  localparam logic [3:0] D_DOWN  = 4'b0100;
  localparam logic [3:0] D_LEFT  = 4'b1000;

  localparam int unsigned     IDX_W    = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
  localparam int unsigned     D_W      = (X_W > Y_W) ? X_W : Y_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

  // Fixed fallback priority UP, LEFT, DOWN, RIGHT.
  function automatic logic [3:0] pick_prio(input logic [3:0] cand);
    if (cand[1])      return D_UP;
    else if (cand[3]) return D_LEFT;
    else if (cand[2]) return D_DOWN;
    else if (cand[0]) return D_RIGHT;
    else              return 4'd0;
  endfunction

  function automatic logic [3:0] reverse_dir(input logic [3:0] d);
    case (d)
      D_RIGHT: return D_LEFT;
      D_LEFT:  return D_RIGHT;
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      default: return 4'd0;
    endcase
  endfunction

  logic                         busy_q, busy_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  mode_e                        mode_q, mode_d, saved_mode_q, saved_mode_d;
  logic [15:0]                  mode_cnt_q, mode_cnt_d, saved_cnt_q, saved_cnt_d;
  logic                         pellet_q, pellet_d;
  logic [15:0]                  lfsr_q, lfsr_d;
  logic                         overrun_q, overrun_d;
  logic                         round_done_q, round_done_d;
  logic [NUM_GHOSTS-1:0][3:0]   move_dir_q, move_dir_d;
  logic [NUM_GHOSTS-1:0][3:0]   prev_dir_q, prev_dir_d;
  logic [NUM_GHOSTS-1:0]        rev_pend_q, rev_pend_d;

  logic        accept;
  logic        rev_all;
  mode_e       adv_mode;
  logic [15:0] adv_cnt;

  assign accept     = tick & ~busy_q;
  assign move_dir   = move_dir_q;
  assign round_done = round_done_q;
  assign mode       = mode_q;
  assign overrun    = overrun_q;

  // LFSR free-runs every clock; pellet latch holds until the next accepted tick.
  always_comb begin
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    pellet_d = accept ? 1'b0 : (pellet_q | power_pellet);
  end

  // Mode sequencer next state: advance the count, then apply a pending pellet on top.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned, which would infer a latch.
    mode_d       = mode_q;
    mode_cnt_d   = mode_cnt_q;
    saved_mode_d = saved_mode_q;
    saved_cnt_d  = saved_cnt_q;
    rev_all      = 1'b0;
    adv_mode     = mode_q;
    adv_cnt      = mode_cnt_q - 16'd1;
    case (mode_q)
      M_SCATTER: if (mode_cnt_q == 16'd1) begin adv_mode = M_CHASE;   adv_cnt = CHASE_TICKS;   end
      M_CHASE:   if (mode_cnt_q == 16'd1) begin adv_mode = M_SCATTER; adv_cnt = SCATTER_TICKS; end
      M_FRIGHT:  if (mode_cnt_q == 16'd1) begin adv_mode = saved_mode_q; adv_cnt = saved_cnt_q; end
      default:   adv_cnt = mode_cnt_q;
    endcase
    if (accept) begin
      if (pellet_q | power_pellet) begin
        mode_d     = M_FRIGHT;
        mode_cnt_d = FRIGHT_TICKS;
        // A pellet during FRIGHT only extends it; the saved mode stays the original one.
        if (mode_q != M_FRIGHT) begin
          saved_mode_d = adv_mode;
          saved_cnt_d  = adv_cnt;
          rev_all      = 1'b1;
        end
      end else begin
        mode_d     = adv_mode;
        mode_cnt_d = adv_cnt;
      end
    end
  end

  int unsigned    g_sel;
  logic [3:0]     g_valid, g_opp, g_allowed, hdir, vdir, prim, sec, rnd, dec_dir;
  logic [X_W-1:0] g_x, tx, dx;
  logic [Y_W-1:0] g_y, ty, dy;

  // Shared decision datapath for the ghost selected by idx_q, inputs sampled live.
  always_comb begin
    g_sel     = 32'(idx_q);
    g_valid   = valid_moves[g_sel*4 +: 4];
    g_x       = ghost_x[g_sel*X_W +: X_W];
    g_y       = ghost_y[g_sel*Y_W +: Y_W];
    g_opp     = reverse_dir(prev_dir_q[g_sel]);
    g_allowed = g_valid & ~g_opp;
    if (g_allowed == 4'd0) g_allowed = g_valid;
    if (mode_q == M_CHASE) begin
      tx = pacman_x;
      ty = pacman_y;
    end else begin
      tx = CORNER_X[g_sel*X_W +: X_W];
      ty = CORNER_Y[g_sel*Y_W +: Y_W];
    end
    dx   = (tx > g_x) ? (tx - g_x) : (g_x - tx);
    dy   = (ty > g_y) ? (ty - g_y) : (g_y - ty);
    hdir = (tx > g_x) ? D_RIGHT : ((tx < g_x) ? D_LEFT : 4'd0);
    vdir = (ty > g_y) ? D_DOWN  : ((ty < g_y) ? D_UP   : 4'd0);
    if (D_W'(dx) >= D_W'(dy)) begin
      prim = hdir;
      sec  = vdir;
    end else begin
      prim = vdir;
      sec  = hdir;
    end
    rnd = lfsr_q[3:0] & g_allowed;
    if (mode_q == M_FRIGHT) begin
      dec_dir = (rnd != 4'd0) ? pick_prio(rnd) : pick_prio(g_allowed);
    end else if ((prim & g_allowed) != 4'd0) begin
      dec_dir = prim;
    end else if ((sec & g_allowed) != 4'd0) begin
      dec_dir = sec;
    end else begin
      dec_dir = pick_prio(g_allowed);
    end
    if (rev_pend_q[g_sel] && ((g_valid & g_opp) != 4'd0)) dec_dir = g_opp;
    if (g_valid == 4'd0) dec_dir = 4'd0;
  end

  // Round control next state: start on an accepted tick, then write one ghost per clock.
  always_comb begin
    busy_d       = busy_q;
    idx_d        = idx_q;
    round_done_d = 1'b0;
    overrun_d    = overrun_q | (tick & busy_q);
    move_dir_d   = move_dir_q;
    prev_dir_d   = prev_dir_q;
    rev_pend_d   = rev_pend_q;
    if (accept) begin
      busy_d = 1'b1;
      idx_d  = '0;
      if (rev_all) rev_pend_d = '1;
    end else if (busy_q) begin
      move_dir_d[g_sel] = dec_dir;
      if (dec_dir != 4'd0) prev_dir_d[g_sel] = dec_dir;
      rev_pend_d[g_sel] = 1'b0;
      if (idx_q == LAST_IDX) begin
        busy_d       = 1'b0;
        round_done_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // State register for the whole block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= 1'b0;
      idx_q        <= '0;
      mode_q       <= M_SCATTER;
      mode_cnt_q   <= SCATTER_TICKS;
      saved_mode_q <= M_SCATTER;
      saved_cnt_q  <= SCATTER_TICKS;
      pellet_q     <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      overrun_q    <= 1'b0;
      round_done_q <= 1'b0;
      // NOTE: the per-ghost arrays are a few flops each, not RAM, so they are reset to give defined outputs and prev_dir.
      move_dir_q   <= '0;
      prev_dir_q   <= '0;
      rev_pend_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      busy_q       <= busy_d;
      idx_q        <= idx_d;
      mode_q       <= mode_d;
      mode_cnt_q   <= mode_cnt_d;
      saved_mode_q <= saved_mode_d;
      saved_cnt_q  <= saved_cnt_d;
      pellet_q     <= pellet_d;
      lfsr_q       <= lfsr_d;
      overrun_q    <= overrun_d;
      round_done_q <= round_done_d;
      move_dir_q   <= move_dir_d;
      prev_dir_q   <= prev_dir_d;
      rev_pend_q   <= rev_pend_d;
    end
  end

endmodule

// File: tb/tb_ghost_ai_multi.sv
// Directed bench for ghost_ai_multi: four ghosts, short mode periods, expected
// round results queued at each tick and compared when round_done pulses.
module tb_ghost_ai_multi;

  localparam int unsigned NG  = 4;
  localparam int unsigned XW  = 11;
  localparam int unsigned YW  = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              tick = 1'b0;
  logic              power_pellet = 1'b0;
  logic [XW-1:0]     pacman_x = XW'(200);
  logic [YW-1:0]     pacman_y = YW'(120);
  logic [NG*XW-1:0]  ghost_x = {11'd500, 11'd50, 11'd300, 11'd100};
  logic [NG*YW-1:0]  ghost_y = {10'd500, 10'd400, 10'd50, 10'd100};
  logic [NG*4-1:0]   valid_moves = '0;
  logic [NG*4-1:0]   move_dir;
  logic              round_done;
  logic [1:0]        mode;
  logic              overrun;

  typedef struct packed {
    logic [15:0] dirs;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  ghost_ai_multi #(
    .NUM_GHOSTS   (NG),
    .X_W          (XW),
    .Y_W          (YW),
    .SCATTER_TICKS(16'd3),
    .CHASE_TICKS  (16'd2),
    .FRIGHT_TICKS (16'd2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .power_pellet(power_pellet),
    .pacman_x    (pacman_x),
    .pacman_y    (pacman_y),
    .ghost_x     (ghost_x),
    .ghost_y     (ghost_y),
    .valid_moves (valid_moves),
    .move_dir    (move_dir),
    .round_done  (round_done),
    .mode        (mode),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one tick, queue the expected result, then wait (bounded) for round_done.
  task automatic run_round(input string tag, input logic [15:0] exp_dirs, input logic [1:0] exp_mode,
                           input logic with_pellet, input bit dup_tick);
    int   n;
    int   extra;
    bit   got;
    exp_t e;
    sb.push_back('{dirs: exp_dirs, mode: exp_mode});
    tick         = 1'b1;
    power_pellet = with_pellet;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      tick         = 1'b0;
      power_pellet = 1'b0;
      if (dup_tick && n == 2) tick = 1'b1;
      if (round_done === 1'b1) got = 1'b1;
    end
    check({tag, " latency"}, n, 5);
    e = sb.pop_front();
    check({tag, " move_dir"}, 32'(move_dir), 32'(e.dirs));
    check({tag, " mode"}, 32'(mode), 32'(e.mode));
    if (dup_tick) begin
      extra = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (round_done === 1'b1) extra++;
      end
      check({tag, " single round_done"}, extra, 0);
      check({tag, " overrun"}, 32'(overrun), 1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset move_dir", 32'(move_dir), 0);
    check("reset mode", 32'(mode), 0);
    check("reset round_done", 32'(round_done), 0);
    check("reset overrun", 32'(overrun), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Valid masks packed {g3,g2,g1,g0}; LEFT=8 DOWN=4 UP=2 RIGHT=1.
    valid_moves = {4'hF, 4'hF, 4'hF, 4'h0};
    run_round("r1 scatter", 16'h8280, 2'b00, 1'b0, 1'b0);
    check("r1 overrun", 32'(overrun), 0);
    valid_moves = {4'h0, 4'hF, 4'h1, 4'h0};
    run_round("r2 dead-end reverse", 16'h0210, 2'b00, 1'b0, 1'b0);
    valid_moves = {4'h1, 4'hF, 4'hA, 4'hF};
    run_round("r3 chase", 16'h1221, 2'b01, 1'b0, 1'b0);
    valid_moves = {4'hF, 4'h0, 4'h4, 4'h2};
    run_round("r4 chase", 16'h2042, 2'b01, 1'b0, 1'b0);
    valid_moves = {4'h0, 4'h0, 4'h2, 4'h0};
    run_round("r5 scatter", 16'h0020, 2'b00, 1'b0, 1'b0);
    valid_moves = {4'h0, 4'hF, 4'h0, 4'h2};
    run_round("r6 overrun", 16'h0202, 2'b00, 1'b0, 1'b1);

    // Pellet latched while idle, consumed by the next tick.
    power_pellet = 1'b1;
    @(posedge clk); #1;
    power_pellet = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    valid_moves = {4'h6, 4'h6, 4'h6, 4'h6};
    run_round("r7 pellet reverse", 16'h4444, 2'b10, 1'b0, 1'b0);
    run_round("r8 pellet in fright", 16'h4444, 2'b10, 1'b1, 1'b0);
    valid_moves = {4'h1, 4'h1, 4'h1, 4'h1};
    run_round("r9 fright", 16'h1111, 2'b10, 1'b0, 1'b0);
    valid_moves = {4'hF, 4'hF, 4'hF, 4'hF};
    run_round("r10 restore scatter", 16'h2222, 2'b00, 1'b0, 1'b0);
    run_round("r11 chase", 16'h2281, 2'b01, 1'b0, 1'b0);

    // Reset while ghost 2 is being evaluated.
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midreset move_dir", 32'(move_dir), 0);
    check("midreset mode", 32'(mode), 0);
    check("midreset overrun", 32'(overrun), 0);
    check("midreset round_done", 32'(round_done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    begin
      int stray;
      stray = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (round_done === 1'b1) stray++;
      end
      check("aborted round no done", stray, 0);
    end
    run_round("r12 after reset", 16'h8288, 2'b00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
